turn_controller: RTL and testbench

Game sequencer that sits between the conditioned user inputs and the board/win-check datapath of the Connect-4 chip. It owns column fill heights, turn order and game state. It validates each requested move and issues a write handshake to the board RAM, then waits for the win checker. In PvE mode it also arbitrates between the human player and the AI move engine.

---
 rtl/connect4_pkg.sv | 44 ++++
 rtl/turn_controller_if.sv | 24 ++
 rtl/column_height_tracker.sv | 46 ++++
 rtl/turn_controller.sv | 211 +++++++++++++++++++++
 tb/tb_turn_controller.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/connect4_pkg.sv
// Shared types and board geometry for the Connect-4 sequencer and its datapath.
package connect4_pkg;
  localparam int COLS   = 7;
  localparam int ROWS   = 6;
  localparam int COL_W  = $clog2(COLS);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int H_W    = $clog2(ROWS + 1);
  localparam int MOVE_W = 6;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    P1   = 2'd1,
    P2   = 2'd2
  } player_t;

  typedef enum logic [2:0] {
    S_WAIT_MOVE = 3'd0,
    S_AI_WAIT   = 3'd1,
    S_WRITE     = 3'd2,
    S_CHECK     = 3'd3,
    S_OVER      = 3'd4
  } tc_state_t;

  typedef struct packed {
    logic             ok;
    logic [COL_W-1:0] idx;
  } sel_t;

  // ok is set only when exactly one bit of v is high; idx is then its position.
  function automatic sel_t onehot_idx(input logic [COLS-1:0] v);
    sel_t r;
    int   n;
    r = '0;
    n = 0;
    for (int i = 0; i < COLS; i++) begin
      if (v[i]) begin
        n++;
        r.idx = COL_W'(i);
      end
    end
    r.ok = (n == 1);
    return r;
  endfunction
endpackage

// File: rtl/turn_controller_if.sv
// Board-write, win-check and AI-move handshake bundle between the sequencer and the datapath.
interface turn_controller_if;
  logic                              wr_valid;
  logic [connect4_pkg::COL_W-1:0]    wr_col;
  logic [connect4_pkg::ROW_W-1:0]    wr_row;
  connect4_pkg::player_t             wr_player;
  logic                              wr_ready;
  logic                              chk_start;
  logic                              chk_done;
  logic                              chk_win;
  logic                              ai_req;
  logic [connect4_pkg::COL_W-1:0]    ai_col;
  logic                              ai_valid;

  modport master (
    output wr_valid, wr_col, wr_row, wr_player, chk_start, ai_req,
    input  wr_ready, chk_done, chk_win, ai_col, ai_valid
  );

  modport slave (
    input  wr_valid, wr_col, wr_row, wr_player, chk_start, ai_req,
    output wr_ready, chk_done, chk_win, ai_col, ai_valid
  );
endinterface

// File: rtl/column_height_tracker.sv
// Per-column fill heights with full flags and the lowest-index column that still has room.
module column_height_tracker
  import connect4_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clr_i,
  input  logic                      inc_i,
  input  logic [COL_W-1:0]          inc_col_i,
  output logic [COLS-1:0][H_W-1:0]  height_o,
  output logic [COLS-1:0]           full_o,
  output logic [COL_W-1:0]          lowest_free_o
);
  logic [COLS-1:0][H_W-1:0] height_q, height_d;

  always_comb begin
    height_d = height_q;
    if (clr_i) begin
      height_d = '0;
    end else if (inc_i) begin
      for (int i = 0; i < COLS; i++) begin
        if (inc_col_i == COL_W'(i) && !full_o[i]) height_d[i] = height_q[i] + H_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) height_q <= '0;
    else        height_q <= height_d;
  end

  always_comb begin
    full_o = '0;
    for (int i = 0; i < COLS; i++) full_o[i] = (height_q[i] == H_W'(ROWS));
  end

  // Scan downward so the last hit is the lowest free index.
  always_comb begin
    lowest_free_o = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!full_o[i]) lowest_free_o = COL_W'(i);
    end
  end

  assign height_o = height_q;
endmodule

// File: rtl/turn_controller.sv
// Connect-4 game sequencer: move validation, board-write handshake, win/draw tracking, PvE arbitration.
// Optional AI_WATCHDOG_EN adds an AI timeout that falls back to the lowest free column.
module turn_controller
  import connect4_pkg::*;
#(
  parameter int AI_TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [COLS-1:0]   move_sel,
  input  logic              confirm,
  input  logic              new_game,
  input  logic              pvp_mode,
  input  logic              first_p2,
  turn_controller_if.master bus,
  output player_t           cur_player,
  output player_t           winner,
  output logic              draw,
  output logic              err_invalid,
  output logic [2:0]        state_dbg
);
  tc_state_t        state_q, state_d;
  player_t          cur_q, cur_d, winner_q, winner_d;
  logic             draw_q, draw_d;
  logic             pvp_q, pvp_d, first_q, first_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [MOVE_W-1:0] moves_q, moves_d;
  logic             err_q, err_d;
  logic             chk_start_q, chk_start_d;
  logic             confirm_q, new_game_q;

  logic             confirm_edge, new_game_edge, handshake, mover_is_ai;
  logic [COLS-1:0][H_W-1:0] height;
  logic [COLS-1:0]  full;
  logic [(1<<COL_W)-1:0] full_ext;
  logic [COL_W-1:0] lowest_free;
  logic             ai_fire;
  logic [COL_W-1:0] ai_pick;
  sel_t             human_sel;

  function automatic logic [ROW_W-1:0] row_of(input logic [COLS-1:0][H_W-1:0] h,
                                              input logic [COL_W-1:0] c);
    logic [ROW_W-1:0] r;
    r = '0;
    for (int i = 0; i < COLS; i++) begin
      if (c == COL_W'(i)) r = ROW_W'(h[i]);
    end
    return r;
  endfunction

  assign confirm_edge  = confirm & ~confirm_q;
  assign new_game_edge = new_game & ~new_game_q;
  assign mover_is_ai   = ~pvp_q & (cur_q == P2);
  assign handshake     = (state_q == S_WRITE) & bus.wr_ready & ~new_game_edge;

  // Column indices beyond COLS-1 read as full, so an out-of-range AI pick falls back.
  always_comb begin
    full_ext = '1;
    full_ext[COLS-1:0] = full;
  end

  column_height_tracker u_heights (
    .clock         (clock),
    .reset         (reset),
    .clr_i         (new_game_edge),
    .inc_i         (handshake),
    .inc_col_i     (col_q),
    .height_o      (height),
    .full_o        (full),
    .lowest_free_o (lowest_free)
  );

`ifdef AI_WATCHDOG_EN
  logic [7:0] wd_cnt_q;
  logic       wd_expired;

  assign wd_expired = (wd_cnt_q == 8'(AI_TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (!reset || state_q != S_AI_WAIT || new_game_edge) wd_cnt_q <= '0;
    else if (!wd_expired)                              wd_cnt_q <= wd_cnt_q + 8'd1;
  end

  assign ai_fire = bus.ai_valid | wd_expired;
  assign ai_pick = (bus.ai_valid && !full_ext[bus.ai_col]) ? bus.ai_col : lowest_free;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = AI_TIMEOUT;
  assign ai_fire = bus.ai_valid;
  assign ai_pick = full_ext[bus.ai_col] ? lowest_free : bus.ai_col;
`endif

  logic unused_first;
  assign unused_first = first_q;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    winner_d    = winner_q;
    draw_d      = draw_q;
    pvp_d       = pvp_q;
    first_d     = first_q;
    col_d       = col_q;
    row_d       = row_q;
    moves_d     = moves_q;
    err_d       = 1'b0;
    chk_start_d = 1'b0;
    human_sel   = onehot_idx(move_sel);

    if (new_game_edge) begin
      pvp_d    = pvp_mode;
      first_d  = first_p2;
      cur_d    = first_p2 ? P2 : P1;
      winner_d = NONE;
      draw_d   = 1'b0;
      moves_d  = '0;
      state_d  = (!pvp_mode && first_p2) ? S_AI_WAIT : S_WAIT_MOVE;
    end else begin
      unique case (state_q)
        S_WAIT_MOVE: begin
          if (confirm_edge && !mover_is_ai) begin
            if (!human_sel.ok || full_ext[human_sel.idx]) begin
              err_d = 1'b1;
            end else begin
              col_d   = human_sel.idx;
              row_d   = row_of(height, human_sel.idx);
              state_d = S_WRITE;
            end
          end
        end
        S_AI_WAIT: begin
          if (ai_fire) begin
            col_d   = ai_pick;
            row_d   = row_of(height, ai_pick);
            state_d = S_WRITE;
          end
        end
        S_WRITE: begin
          if (bus.wr_ready) begin
            moves_d     = moves_q + MOVE_W'(1);
            chk_start_d = 1'b1;
            state_d     = S_CHECK;
          end
        end
        S_CHECK: begin
          if (bus.chk_done) begin
            if (bus.chk_win) begin
              winner_d = cur_q;
              state_d  = S_OVER;
            end else if (moves_q == MOVE_W'(COLS * ROWS)) begin
              draw_d  = 1'b1;
              state_d = S_OVER;
            end else begin
              cur_d   = (cur_q == P1) ? P2 : P1;
              state_d = (!pvp_q && cur_d == P2) ? S_AI_WAIT : S_WAIT_MOVE;
            end
          end
        end
        S_OVER:  state_d = S_OVER;
        default: state_d = S_WAIT_MOVE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_WAIT_MOVE;
      cur_q       <= P1;
      winner_q    <= NONE;
      draw_q      <= 1'b0;
      pvp_q       <= 1'b1;
      first_q     <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      moves_q     <= '0;
      err_q       <= 1'b0;
      chk_start_q <= 1'b0;
      confirm_q   <= 1'b0;
      new_game_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      winner_q    <= winner_d;
      draw_q      <= draw_d;
      pvp_q       <= pvp_d;
      first_q     <= first_d;
      col_q       <= col_d;
      row_q       <= row_d;
      moves_q     <= moves_d;
      err_q       <= err_d;
      chk_start_q <= chk_start_d;
      confirm_q   <= confirm;
      new_game_q  <= new_game;
    end
  end

  // A restart withdraws any pending write in the same cycle.
  assign bus.wr_valid  = (state_q == S_WRITE) & ~new_game_edge;
  assign bus.wr_col    = col_q;
  assign bus.wr_row    = row_q;
  assign bus.wr_player = cur_q;
  assign bus.chk_start = chk_start_q;
  assign bus.ai_req    = (state_q == S_AI_WAIT);

  assign cur_player  = cur_q;
  assign winner      = winner_q;
  assign draw        = draw_q;
  assign err_invalid = err_q;
  assign state_dbg   = state_q;
endmodule

// File: tb/tb_turn_controller.sv
// Self-checking bench for turn_controller against a board-level game model.
module tb_turn_controller;
  import connect4_pkg::*;

  logic            clock = 1'b0;
  logic            reset;
  logic [COLS-1:0] move_sel;
  logic            confirm, new_game, pvp_mode, first_p2;
  player_t         cur_player, winner;
  logic            draw, err_invalid;
  logic [2:0]      state_dbg;

  always #5 clock = ~clock;

  turn_controller_if bus ();

  turn_controller dut (
    .clock       (clock),
    .reset       (reset),
    .move_sel    (move_sel),
    .confirm     (confirm),
    .new_game    (new_game),
    .pvp_mode    (pvp_mode),
    .first_p2    (first_p2),
    .bus         (bus),
    .cur_player  (cur_player),
    .winner      (winner),
    .draw        (draw),
    .err_invalid (err_invalid),
    .state_dbg   (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // Game model: column fill counts, player to move, move count, outcome.
  int mh[COLS];
  int mplayer;
  int mmoves;
  bit mpvp;
  int mwinner;
  bit mdraw;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int exp_state();
    if (mwinner != 0 || mdraw) return 4;
    if (!mpvp && mplayer == 2) return 1;
    return 0;
  endfunction

  function automatic int model_lowest_free();
    for (int c = 0; c < COLS; c++) if (mh[c] < ROWS) return c;
    return 0;
  endfunction

  function automatic int random_open_col();
    int c;
    c = $urandom_range(0, COLS - 1);
    for (int k = 0; k < COLS; k++) begin
      if (mh[c] < ROWS) return c;
      c = (c + 1) % COLS;
    end
    return 0;
  endfunction

  task automatic model_new(input bit pvp, input bit fp2);
    mpvp    = pvp;
    mplayer = fp2 ? 2 : 1;
    mmoves  = 0;
    mwinner = 0;
    mdraw   = 1'b0;
    for (int c = 0; c < COLS; c++) mh[c] = 0;
  endtask

  task automatic start_game(input bit pvp, input bit fp2);
    pvp_mode = pvp;
    first_p2 = fp2;
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    tick();
    model_new(pvp, fp2);
    check("ng_state", 32'(state_dbg), 32'(exp_state()));
    check("ng_player", 32'(cur_player), 32'(mplayer));
    check("ng_winner", 32'(winner), 32'd0);
    check("ng_draw", 32'(draw), 32'd0);
  endtask

  // Entered one cycle after the move was committed: the write should be on the bus.
  task automatic finish_move(input int col, input bit win, input int stall);
    check("wr_valid", 32'(bus.wr_valid), 32'd1);
    check("wr_col", 32'(bus.wr_col), 32'(col));
    check("wr_row", 32'(bus.wr_row), 32'(mh[col]));
    check("wr_player", 32'(bus.wr_player), 32'(mplayer));
    for (int s = 0; s < stall; s++) begin
      tick();
      check("stall_valid", 32'(bus.wr_valid), 32'd1);
      check("stall_col", 32'(bus.wr_col), 32'(col));
    end
    bus.wr_ready = 1'b1;
    tick();
    bus.wr_ready = 1'b0;
    check("chk_start", 32'(bus.chk_start), 32'd1);
    check("post_wr_valid", 32'(bus.wr_valid), 32'd0);
    bus.chk_done = 1'b1;
    bus.chk_win  = win;
    tick();
    bus.chk_done = 1'b0;
    bus.chk_win  = 1'b0;
    mh[col]++;
    mmoves++;
    if (win)                      mwinner = mplayer;
    else if (mmoves == COLS*ROWS) mdraw = 1'b1;
    else                          mplayer = 3 - mplayer;
    check("chk_start_pulse", 32'(bus.chk_start), 32'd0);
    check("mv_state", 32'(state_dbg), 32'(exp_state()));
    check("mv_player", 32'(cur_player), 32'(mplayer));
    check("mv_winner", 32'(winner), 32'(mwinner));
    check("mv_draw", 32'(draw), 32'(mdraw));
  endtask

  task automatic human_move(input int col, input bit win, input int stall);
    logic [COLS-1:0] sel;
    sel = '0;
    sel[col] = 1'b1;
    move_sel = sel;
    confirm  = 1'b1;
    tick();
    confirm = 1'b0;
    finish_move(col, win, stall);
  endtask

  task automatic ai_move(input int req, input int stall);
    int pick;
    check("ai_req", 32'(bus.ai_req), 32'd1);
    check("ai_state", 32'(state_dbg), 32'd1);
    pick = model_lowest_free();
    if (req < COLS) begin
      if (mh[req] < ROWS) pick = req;
    end
    bus.ai_col   = COL_W'(req);
    bus.ai_valid = 1'b1;
    tick();
    bus.ai_valid = 1'b0;
    check("ai_req_drop", 32'(bus.ai_req), 32'd0);
    check("ai_no_err", 32'(err_invalid), 32'd0);
    finish_move(pick, 1'b0, stall);
  endtask

  task automatic bad_move(input logic [COLS-1:0] sel, input string tag);
    move_sel = sel;
    confirm  = 1'b1;
    tick();
    confirm = 1'b0;
    check({tag, "_err"}, 32'(err_invalid), 32'd1);
    check({tag, "_nowr"}, 32'(bus.wr_valid), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'(exp_state()));
    tick();
    check({tag, "_errpulse"}, 32'(err_invalid), 32'd0);
  endtask

  task automatic ignored_confirm(input string tag);
    move_sel = 7'b0001000;
    confirm  = 1'b1;
    tick();
    confirm = 1'b0;
    check({tag, "_err"}, 32'(err_invalid), 32'd0);
    check({tag, "_nowr"}, 32'(bus.wr_valid), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'(exp_state()));
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int c;
    reset        = 1'b0;
    move_sel     = '0;
    confirm      = 1'b0;
    new_game     = 1'b0;
    pvp_mode     = 1'b1;
    first_p2     = 1'b0;
    bus.wr_ready = 1'b0;
    bus.chk_done = 1'b0;
    bus.chk_win  = 1'b0;
    bus.ai_col   = '0;
    bus.ai_valid = 1'b0;
    tick();
    tick();
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_player", 32'(cur_player), 32'd1);
    check("rst_winner", 32'(winner), 32'd0);
    check("rst_draw", 32'(draw), 32'd0);
    check("rst_wr_valid", 32'(bus.wr_valid), 32'd0);
    check("rst_ai_req", 32'(bus.ai_req), 32'd0);
    check("rst_err", 32'(err_invalid), 32'd0);
    check("rst_chk_start", 32'(bus.chk_start), 32'd0);
    reset = 1'b1;

    // PvP: single move, then fill column 0 and bounce off it.
    start_game(1'b1, 1'b0);
    human_move(2, 1'b0, 0);
    for (int i = 0; i < ROWS; i++) human_move(0, 1'b0, $urandom_range(0, 3));
    bad_move(7'b0000001, "full_col");
    bad_move(7'b0000110, "two_hot");
    bad_move(7'b0000000, "zero_hot");
    for (int i = 0; i < 8; i++) human_move(random_open_col(), 1'b0, $urandom_range(0, 2));

    // PvE: fill column 0, then an AI request for it falls back to column 1.
    start_game(1'b0, 1'b0);
    for (int i = 0; i < ROWS / 2; i++) begin
      human_move(0, 1'b0, 0);
      ai_move(0, 0);
    end
    human_move(3, 1'b0, 0);
    ignored_confirm("ai_turn_confirm");
    ai_move(0, 1);
    for (int i = 0; i < 10; i++) begin
      human_move(random_open_col(), 1'b0, $urandom_range(0, 2));
      ai_move($urandom_range(0, COLS), $urandom_range(0, 2));
    end

    // AI opens; an out-of-range request takes the lowest free column.
    start_game(1'b0, 1'b1);
    ai_move(COLS, 0);

    // Restart while a write is stalled.
    start_game(1'b1, 1'b0);
    move_sel = 7'b0010000;
    confirm  = 1'b1;
    tick();
    confirm = 1'b0;
    for (int s = 0; s < 5; s++) begin
      check("hold_valid", 32'(bus.wr_valid), 32'd1);
      tick();
    end
    new_game = 1'b1;
    #1;
    check("ng_drops_valid", 32'(bus.wr_valid), 32'd0);
    tick();
    new_game = 1'b0;
    model_new(1'b1, 1'b0);
    check("ng_mid_state", 32'(state_dbg), 32'd0);
    check("ng_mid_player", 32'(cur_player), 32'd1);
    bus.chk_done = 1'b1;
    bus.chk_win  = 1'b1;
    tick();
    bus.chk_done = 1'b0;
    bus.chk_win  = 1'b0;
    check("stale_done_state", 32'(state_dbg), 32'd0);
    check("stale_done_winner", 32'(winner), 32'd0);
    check("stale_done_player", 32'(cur_player), 32'd1);
    human_move(4, 1'b0, 0);

    // Win on the opening P1 move, then confirms are ignored.
    start_game(1'b1, 1'b0);
    human_move(1, 1'b1, 0);
    ignored_confirm("over_confirm");
    check("over_winner_hold", 32'(winner), 32'd1);

    // Full board without a win.
    start_game(1'b1, 1'b1);
    for (int i = 0; i < COLS * ROWS; i++) human_move(random_open_col(), 1'b0, $urandom_range(0, 2));
    check("draw_flag", 32'(draw), 32'd1);
    ignored_confirm("draw_confirm");
    check("draw_hold", 32'(draw), 32'd1);

`ifdef AI_WATCHDOG_EN
    start_game(1'b0, 1'b1);
    c = 0;
    while (!bus.wr_valid && c < 400) begin
      tick();
      c++;
    end
    check("wd_fired", 32'(bus.wr_valid), 32'd1);
    check("wd_not_early", 32'(c >= 250), 32'd1);
    finish_move(0, 1'b0, 0);
`else
    c = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
